lsu_unit: RTL and testbench
===========================

LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles spent in ISSUE+WAIT before error completion.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  execute stage presents a load/store.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_wen  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  in  1  zero-extend load result (lbu/lhu).
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data to register file.
REQ-013 resp_err  out  1  completion is an error (misaligned, illegal size, timeout).
REQ-014 mem_valid  out  1  memory request valid.
REQ-015 mem_ready  in  1  memory accepts request.
REQ-016 mem_addr  out  32  word-aligned address.
REQ-017 mem_wen  out  1  memory write.
REQ-018 mem_wmask  out  4  byte-lane write enables.
REQ-019 mem_wdata  out  32  lane-aligned store data.
REQ-020 mem_rvalid  in  1  read data / write acknowledge.
REQ-021 mem_rdata  in  32  word read data.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-023 On req_valid&&req_ready, all req_* fields SHALL be latched; later input changes have no effect.
REQ-024 A misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL go IDLE->RESP with resp_err=1, resp_rdata=0, no mem_valid.
REQ-025 Otherwise IDLE->ISSUE; in ISSUE mem_valid=1 and mem_addr/mem_wen/mem_wmask/mem_wdata held stable until mem_valid&&mem_ready, then ->WAIT.
REQ-026 mem_addr = {addr[31:2],2'b00}; mem_wen = latched req_wen.
REQ-027 mem_wmask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads 4'b0000.
REQ-028 mem_wdata = req_wdata << (8*addr[1:0]).
REQ-029 mem_rvalid SHALL be sampled only in WAIT; in any other state it is ignored. Stores also wait for mem_rvalid as acknowledge.
REQ-030 On mem_rvalid in WAIT: ->RESP; load data = mem_rdata >> (8*addr[1:0]), low 8/16/32 bits, sign-extended unless req_unsigned; store result = 0.
REQ-031 Timeout counter SHALL clear on accept, increment each cycle in ISSUE or WAIT; on reaching TIMEOUT ->RESP with resp_err=1, resp_rdata=0.
REQ-032 mem_rvalid and timeout in the same cycle: rvalid wins, resp_err=0.
REQ-033 RESP SHALL last exactly one cycle (resp_valid=1), then ->IDLE; no response backpressure.
REQ-034 resp_rdata and resp_err SHALL hold their last value until the next RESP.
REQ-035 Latency, zero-wait memory: accept in cycle N, ISSUE N+1, WAIT N+2, resp_valid in cycle N+3; error path resp_valid in N+1.

Reset
REQ-036 On rst assertion, immediately and independent of clk: state IDLE, req_ready=1, all other outputs 0, counter and latched fields 0.
REQ-037 Reset during ISSUE/WAIT SHALL abort the transaction with no resp_valid; mem_valid drops asynchronously.

Verification
REQ-038 lw addr 0x100, mem_rdata 0xDEADBEEF, zero-wait -> mem_wmask 0000, resp_valid at N+3, resp_rdata 0xDEADBEEF, err 0.
REQ-039 lb addr 0x103, mem_rdata 0x80FF0000 -> resp_rdata 0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
REQ-040 sb addr 0x202, wdata 0x000000AB -> mem_addr 0x200, wmask 0100, mem_wdata 0x00AB0000; sh addr 0x202 -> wmask 1100.
REQ-041 lw addr 0x102 -> resp_valid at N+1, resp_err 1, mem_valid never asserted; size 11 likewise.
REQ-042 mem_ready held 0 for 3 cycles, rvalid 2 cycles later -> mem_valid and fields stable throughout, single resp_valid; with TIMEOUT=4 and no rvalid -> resp_err 1 after 4 cycles.
REQ-043 rst asserted during WAIT -> req_ready 1 and mem_valid 0 without clock edge; late mem_rvalid produces no response.

Source files
------------

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// lsu_if : request/response and memory-side bus bundle for lsu_unit
// Rev 1.0
// ============================================================================
interface lsu_if;
    // execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;

    // completion towards register file
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // memory port
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_unit.sv
`default_nettype none
// ============================================================================
// lsu_unit : single-outstanding load/store unit with alignment checks,
//            byte-lane steering, load extension and a request timeout
// Rev 1.0
// ============================================================================
module lsu_unit #(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rst,
    lsu_if.slave      bus
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               wen_q, wen_d;
    logic [31:0]        addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               req_bad;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cnt_hit;
    logic [31:0]        rd_shift;
    logic [31:0]        load_data;
    logic [3:0]         wmask;

    // Alignment / size legality is judged on the live request so the error
    // path can skip ISSUE entirely.
    always_comb begin
        req_bad = 1'b0;
        unique case (bus.req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = bus.req_addr[0];
            2'b10:   req_bad = |bus.req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign cnt_hit = (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        rd_shift  = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        load_data = rd_shift;
        unique case (size_q)
            2'b00:   load_data = {{24{~uns_q & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   load_data = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_comb begin
        wmask = 4'b0000;
        if (wen_q) begin
            unique case (size_q)
                2'b00:   wmask = 4'b0001 << addr_q[1:0];
                2'b01:   wmask = 4'b0011 << addr_q[1:0];
                2'b10:   wmask = 4'b1111;
                default: wmask = 4'b0000;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    wen_d   = bus.req_wen;
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata;
                    cnt_d   = '0;
                    if (req_bad) begin
                        state_d = S_RESP;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_inc;
                if (cnt_hit) begin
                    state_d = S_RESP;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A response arriving on the timeout cycle still counts as success.
                if (bus.mem_rvalid) begin
                    state_d = S_RESP;
                    rdata_d = wen_q ? 32'h0 : load_data;
                    err_d   = 1'b0;
                end else if (cnt_hit) begin
                    state_d = S_RESP;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wen_q   <= 1'b0;
            addr_q  <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode directly from flops, so reset clears them without a clock.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.mem_valid  = (state_q == S_ISSUE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wen    = wen_q;
    assign bus.mem_wmask  = wmask;
    assign bus.mem_wdata  = wdata_q << {addr_q[1:0], 3'b000};

endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// ============================================================================
// tb_lsu_unit : directed self-checking bench for lsu_unit (default and
//               TIMEOUT=4 instances)
// Rev 1.0
// ============================================================================
module tb_lsu_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    lsu_if bus ();
    lsu_if bus_t ();

    lsu_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lsu_unit #(.TIMEOUT(4)) u_dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid    = 1'b0; bus_t.req_valid    = 1'b0;
        bus.req_wen      = 1'b0; bus_t.req_wen      = 1'b0;
        bus.req_addr     = 32'h0; bus_t.req_addr    = 32'h0;
        bus.req_size     = 2'b10; bus_t.req_size    = 2'b10;
        bus.req_unsigned = 1'b0; bus_t.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0; bus_t.req_wdata   = 32'h0;
        bus.mem_ready    = 1'b0; bus_t.mem_ready    = 1'b0;
        bus.mem_rvalid   = 1'b0; bus_t.mem_rvalid   = 1'b0;
        bus.mem_rdata    = 32'h0; bus_t.mem_rdata   = 32'h0;
    endtask

    // Zero-wait transaction on the default instance; entered at a negedge with DUT idle.
    task automatic xfer(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] mrdata, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_addr = addr;
        bus.req_size = size; bus.req_unsigned = uns; bus.req_wdata = wdata;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_wen = ~wen; bus.req_addr = ~addr;
        bus.req_size = ~size; bus.req_unsigned = ~uns; bus.req_wdata = ~wdata;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = ~mrdata;
        chk({tag, ".issue_mem_valid"}, bus.mem_valid, 1);
        chk({tag, ".issue_req_ready"}, bus.req_ready, 0);
        chk({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".mem_wen"}, bus.mem_wen, wen);
        chk({tag, ".mem_wmask"}, bus.mem_wmask, exp_mask);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, exp_wdata);
        @(negedge clk);
        chk({tag, ".wait_mem_valid"}, bus.mem_valid, 0);
        chk({tag, ".wait_resp_valid"}, bus.resp_valid, 0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = mrdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b0;
        chk({tag, ".resp_valid"}, bus.resp_valid, 1);
        chk({tag, ".resp_rdata"}, bus.resp_rdata, exp_rdata);
        chk({tag, ".resp_err"}, bus.resp_err, 0);
        @(negedge clk);
        chk({tag, ".after_resp_valid"}, bus.resp_valid, 0);
        chk({tag, ".after_req_ready"}, bus.req_ready, 1);
        chk({tag, ".rdata_hold"}, bus.resp_rdata, exp_rdata);
    endtask

    task automatic err_req(input string tag, input logic [31:0] addr, input logic [1:0] size);
        bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = addr; bus.req_size = size;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.mem_ready = 1'b0;
        chk({tag, ".resp_valid"}, bus.resp_valid, 1);
        chk({tag, ".resp_err"}, bus.resp_err, 1);
        chk({tag, ".resp_rdata"}, bus.resp_rdata, 0);
        chk({tag, ".mem_valid"}, bus.mem_valid, 0);
        @(negedge clk);
        chk({tag, ".after_resp_valid"}, bus.resp_valid, 0);
        chk({tag, ".after_mem_valid"}, bus.mem_valid, 0);
        chk({tag, ".err_hold"}, bus.resp_err, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        chk("rst.req_ready", bus.req_ready, 1);
        chk("rst.mem_valid", bus.mem_valid, 0);
        chk("rst.resp_valid", bus.resp_valid, 0);
        chk("rst.resp_rdata", bus.resp_rdata, 0);
        chk("rst.resp_err", bus.resp_err, 0);
        chk("rst.mem_wmask", bus.mem_wmask, 0);
        chk("rst.mem_addr", bus.mem_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        xfer("lw_100",  1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h0, 32'hDEADBEEF);
        xfer("sb_202",  1'b1, 32'h202, 2'b00, 1'b0, 32'h000000AB, 32'h12345678, 4'b0100, 32'h00AB0000, 32'h0);
        xfer("lb_103",  1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 32'h80FF0000, 4'b0000, 32'h0, 32'hFFFFFF80);
        xfer("lbu_103", 1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 32'h80FF0000, 4'b0000, 32'h0, 32'h00000080);
        xfer("sh_202",  1'b1, 32'h202, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, 4'b1100, 32'hBEEF0000, 32'h0);
        xfer("lh_102",  1'b0, 32'h102, 2'b01, 1'b0, 32'h0, 32'h80011234, 4'b0000, 32'h0, 32'hFFFF8001);
        xfer("lhu_102", 1'b0, 32'h102, 2'b01, 1'b1, 32'h0, 32'h80011234, 4'b0000, 32'h0, 32'h00008001);
        xfer("sw_300",  1'b1, 32'h300, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0);
        xfer("lb_101",  1'b0, 32'h101, 2'b00, 1'b0, 32'h0, 32'h00007F00, 4'b0000, 32'h0, 32'h0000007F);
        xfer("sb_001",  1'b1, 32'h001, 2'b00, 1'b0, 32'h00000055, 32'h0, 4'b0010, 32'h00005500, 32'h0);

        err_req("lw_102_misal", 32'h102, 2'b10);
        err_req("sz11_100",     32'h100, 2'b11);
        err_req("lh_101_misal", 32'h101, 2'b01);

        // Backpressure: mem_ready low for 3 ISSUE cycles, rvalid two cycles after handshake
        bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = 32'h10A;
        bus.req_size = 2'b01; bus.req_wdata = 32'h00001122; bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = (i == 1);
            bus.mem_ready  = (i == 3);
            chk("bp.mem_valid", bus.mem_valid, 1);
            chk("bp.mem_addr", bus.mem_addr, 32'h108);
            chk("bp.mem_wmask", bus.mem_wmask, 4'b1100);
            chk("bp.mem_wdata", bus.mem_wdata, 32'h11220000);
            chk("bp.resp_valid", bus.resp_valid, 0);
            @(negedge clk);
        end
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        chk("bp.wait1_mem_valid", bus.mem_valid, 0);
        chk("bp.wait1_resp_valid", bus.resp_valid, 0);
        @(negedge clk);
        chk("bp.wait2_resp_valid", bus.resp_valid, 0);
        bus.mem_rvalid = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("bp.resp_valid", bus.resp_valid, 1);
        chk("bp.resp_err", bus.resp_err, 0);
        chk("bp.resp_rdata", bus.resp_rdata, 0);
        @(negedge clk);
        chk("bp.single_pulse", bus.resp_valid, 0);

        // TIMEOUT=4 instance: rvalid on the timeout cycle wins
        bus_t.req_valid = 1'b1; bus_t.req_addr = 32'h400; bus_t.req_size = 2'b10;
        bus_t.mem_ready = 1'b1;
        @(negedge clk);
        bus_t.req_valid = 1'b0;
        chk("tw.issue_mem_valid", bus_t.mem_valid, 1);
        @(negedge clk);
        @(negedge clk);
        chk("tw.n3_resp_valid", bus_t.resp_valid, 0);
        @(negedge clk);
        chk("tw.n4_resp_valid", bus_t.resp_valid, 0);
        bus_t.mem_rvalid = 1'b1; bus_t.mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        bus_t.mem_rvalid = 1'b0;
        chk("tw.resp_valid", bus_t.resp_valid, 1);
        chk("tw.resp_err", bus_t.resp_err, 0);
        chk("tw.resp_rdata", bus_t.resp_rdata, 32'h55AA55AA);
        @(negedge clk);

        // Timeout in WAIT
        bus_t.req_valid = 1'b1;
        @(negedge clk);
        bus_t.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("to_wait.n4_resp_valid", bus_t.resp_valid, 0);
        @(negedge clk);
        chk("to_wait.resp_valid", bus_t.resp_valid, 1);
        chk("to_wait.resp_err", bus_t.resp_err, 1);
        chk("to_wait.resp_rdata", bus_t.resp_rdata, 0);
        @(negedge clk);

        // Timeout while stuck in ISSUE
        bus_t.mem_ready = 1'b0; bus_t.req_valid = 1'b1;
        @(negedge clk);
        bus_t.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("to_issue.n4_mem_valid", bus_t.mem_valid, 1);
        chk("to_issue.n4_resp_valid", bus_t.resp_valid, 0);
        @(negedge clk);
        chk("to_issue.resp_valid", bus_t.resp_valid, 1);
        chk("to_issue.resp_err", bus_t.resp_err, 1);
        chk("to_issue.mem_valid", bus_t.mem_valid, 0);
        @(negedge clk);

        // Reset during ISSUE: mem_valid must drop with no clock edge
        bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = 32'h500;
        bus.req_size = 2'b10; bus.req_wdata = 32'hA5A5A5A5; bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_issue.pre_mem_valid", bus.mem_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_issue.mem_valid", bus.mem_valid, 0);
        chk("rst_issue.req_ready", bus.req_ready, 1);
        chk("rst_issue.mem_wmask", bus.mem_wmask, 0);
        chk("rst_issue.mem_wdata", bus.mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset during WAIT, then a late rvalid must not produce a response
        bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 32'h100; bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_wait.pre_req_ready", bus.req_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait.req_ready", bus.req_ready, 1);
        chk("rst_wait.mem_valid", bus.mem_valid, 0);
        @(negedge clk);
        rst = 1'b0; bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wait.late_rvalid_resp", bus.resp_valid, 0);
        end
        bus.mem_rvalid = 1'b0;
        chk("rst_wait.resp_rdata", bus.resp_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
